// File: rtl/flexbex_prefetch_queue.sv
// flexbex_prefetch_queue: instruction prefetch FIFO with multiple outstanding fetches, branch flush and stale-response discard; ports: req/branch/addr/ready in, valid/rdata/addr out, instr_* memory bus, busy/fill status
module flexbex_prefetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_i,
  input  logic                         branch_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [ADDR_W-1:0]            addr_o,
  output logic                         instr_req_o,
  output logic [ADDR_W-1:0]            instr_addr_o,
  input  logic                         instr_gnt_i,
  input  logic                         instr_rvalid_i,
  input  logic [DATA_W-1:0]            instr_rdata_i,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o
);
  localparam int STRIDE = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = FW + 1;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, head_addr_q, head_addr_d, target;
  logic [OW-1:0] out_q, out_d, disc_q, disc_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [PW-1:0] rd_q, wr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0] live;
  logic gnt, rvalid, push, pop;
  assign target = addr_i & ~ADDR_W'(STRIDE - 1);
  always_comb begin
    // a branch flushes the FIFO and turns every in-flight response stale, so nothing live remains
    live = branch_i ? CW'(0) : CW'(fill_q) + CW'(out_q) - CW'(disc_q);
    instr_req_o = ~rst & req_i & (live < CW'(DEPTH)) & (out_q < OW'(MAX_OUTSTANDING));
    instr_addr_o = branch_i ? target : fetch_addr_q;
    gnt = instr_req_o & instr_gnt_i;
    rvalid = instr_rvalid_i & (out_q != '0);
    push = rvalid & (disc_q == '0) & ~branch_i;
    pop = (fill_q != '0) & ready_i & ~branch_i;
    out_d = out_q + OW'(gnt) - OW'(rvalid);
    disc_d = branch_i ? out_q - OW'(rvalid) : disc_q - OW'(rvalid && disc_q != '0);
    fill_d = branch_i ? '0 : fill_q + FW'(push) - FW'(pop);
    head_addr_d = branch_i ? target : pop ? head_addr_q + ADDR_W'(STRIDE) : head_addr_q;
    // a grant in the branch cycle already belongs to the new stream
    fetch_addr_d = gnt ? instr_addr_o + ADDR_W'(STRIDE) : branch_i ? target : fetch_addr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr_q <= '0;
      head_addr_q <= '0;
      out_q <= '0;
      disc_q <= '0;
      fill_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_addr_q <= head_addr_d;
      out_q <= out_d;
      disc_q <= disc_d;
      fill_q <= fill_d;
      rd_q <= branch_i ? '0 : pop ? rd_q + PW'(1) : rd_q;
      wr_q <= branch_i ? '0 : push ? wr_q + PW'(1) : wr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= instr_rdata_i;
  end
  assign valid_o = fill_q != '0;
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  assign addr_o = head_addr_q;
  assign fill_o = fill_q;
  assign busy_o = instr_req_o | (out_q != '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && fill_q == FW'(DEPTH)));
endmodule

// File: tb/tb_flexbex_prefetch_queue.sv
// tb_flexbex_prefetch_queue: queue-based reference model plus directed scenarios for the prefetch queue
module tb_flexbex_prefetch_queue;
  logic clk = 0, rst, req_i, branch_i, ready_i, instr_gnt_i, instr_rvalid_i;
  logic [31:0] addr_i, instr_rdata_i, rdata_o, addr_o, instr_addr_o;
  logic valid_o, instr_req_o, busy_o;
  logic [2:0] fill_o;
  logic q_req, q_br, q_rdy, q_gnt, q_rv, q_valid, q_ireq, q_busy;
  logic [31:0] q_addr, q_addr_o, q_iaddr;
  logic [63:0] q_rdi, q_rdata;
  logic [2:0] q_fill;
  int checks = 0, errors = 0, cyc = 0, lat = 1;
  bit found;
  always #5 clk = ~clk;
  flexbex_prefetch_queue dut (.clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .busy_o(busy_o), .fill_o(fill_o));
  flexbex_prefetch_queue #(.DATA_W(64)) dut64 (.clk(clk), .rst(rst), .req_i(q_req), .branch_i(q_br),
    .addr_i(q_addr), .ready_i(q_rdy), .valid_o(q_valid), .rdata_o(q_rdata), .addr_o(q_addr_o),
    .instr_req_o(q_ireq), .instr_addr_o(q_iaddr), .instr_gnt_i(q_gnt), .instr_rvalid_i(q_rv),
    .instr_rdata_i(q_rdi), .busy_o(q_busy), .fill_o(q_fill));
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]};
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  typedef struct { logic [31:0] a; int due; } rq_t;
  rq_t rq[$];
  always @(negedge clk) begin
    if (instr_rvalid_i && rq.size() > 0) void'(rq.pop_front());
    if (instr_req_o && instr_gnt_i) rq.push_back('{instr_addr_o, cyc + lat});
    cyc++;
  end
  always @(posedge clk) begin
    #1;
    instr_rvalid_i = rq.size() > 0 && rq[0].due <= cyc;
    instr_rdata_i = instr_rvalid_i ? memf(rq[0].a) : 32'h0;
  end
  typedef struct { logic [31:0] a; bit stale; } ifl_t;
  ifl_t ifl[$];
  logic [31:0] fq[$];
  logic [31:0] nxt, head;
  always @(negedge clk) begin
    int live;
    bit er, r, g, psh;
    logic [31:0] ea;
    ifl_t e;
    if (rst) begin
      ifl.delete();
      fq.delete();
      nxt = 0;
      head = 0;
      chk("rst_valid", valid_o, 0);
      chk("rst_req", instr_req_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_fill", fill_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_iaddr", instr_addr_o, 0);
      chk("rst_rdata", rdata_o, 0);
    end else begin
      live = 0;
      if (!branch_i) begin
        live = fq.size();
        foreach (ifl[i]) if (!ifl[i].stale) live++;
      end
      er = req_i && live < 4 && ifl.size() < 2;
      ea = branch_i ? {addr_i[31:2], 2'b00} : nxt;
      chk("m_req", instr_req_o, er);
      chk("m_iaddr", instr_addr_o, ea);
      chk("m_busy", busy_o, er || ifl.size() != 0);
      chk("m_valid", valid_o, fq.size() != 0);
      chk("m_fill", fill_o, fq.size());
      chk("m_addr", addr_o, head);
      if (fq.size() != 0) chk("m_rdata", rdata_o, memf(fq[0]));
      r = instr_rvalid_i && ifl.size() > 0;
      g = er && instr_gnt_i;
      psh = 0;
      if (r) begin
        e = ifl.pop_front();
        psh = !e.stale && !branch_i;
      end
      if (branch_i) begin
        fq.delete();
        foreach (ifl[i]) ifl[i].stale = 1;
        head = ea;
      end else begin
        if (ready_i && fq.size() > 0) begin
          void'(fq.pop_front());
          head += 4;
        end
        if (psh) fq.push_back(e.a);
      end
      if (g) begin
        ifl.push_back('{ea, 1'b0});
        nxt = ea + 4;
      end else if (branch_i) nxt = ea;
    end
  end
  initial begin
    rst = 1; req_i = 0; branch_i = 0; addr_i = 0; ready_i = 0; instr_gnt_i = 0;
    q_req = 0; q_br = 0; q_addr = 0; q_rdy = 0; q_gnt = 0; q_rv = 0; q_rdi = 0;
    tick(); tick();
    rst = 0; req_i = 1; branch_i = 1; addr_i = 32'h82; instr_gnt_i = 1; ready_i = 1;
    @(negedge clk); chk("b80_iaddr", instr_addr_o, 32'h80); chk("b80_req", instr_req_o, 1);
    tick(); branch_i = 0;
    @(negedge clk); chk("b80_t1_valid", valid_o, 0);
    tick();
    @(negedge clk); chk("b80_t2_valid", valid_o, 1); chk("b80_t2_addr", addr_o, 32'h80);
    chk("b80_t2_rdata", rdata_o, memf(32'h80));
    tick();
    @(negedge clk); chk("b80_t3_addr", addr_o, 32'h84);
    tick();
    @(negedge clk); chk("b80_t4_addr", addr_o, 32'h88);
    ready_i = 0;
    repeat (8) tick();
    @(negedge clk); chk("full_fill", fill_o, 4); chk("full_req", instr_req_o, 0); chk("full_busy", busy_o, 0);
    tick(); ready_i = 1;
    @(negedge clk); chk("pop_req", instr_req_o, 0);
    tick(); ready_i = 0;
    @(negedge clk); chk("resume_fill", fill_o, 3); chk("resume_req", instr_req_o, 1);
    tick(); ready_i = 1; lat = 3;
    repeat (8) tick();
    branch_i = 1; addr_i = 32'h200;
    tick(); branch_i = 0;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin @(negedge clk); found = valid_o; end
    chk("b200_seen", found, 1); chk("b200_addr", addr_o, 32'h200); chk("b200_rdata", rdata_o, memf(32'h200));
    tick(); lat = 1;
    repeat (6) tick();
    branch_i = 1; addr_i = 32'h300;
    @(negedge clk); chk("b300_rvalid", instr_rvalid_i, 1); chk("b300_req", instr_req_o, 1);
    chk("b300_iaddr", instr_addr_o, 32'h300);
    tick(); branch_i = 0;
    @(negedge clk); chk("b300_t1_valid", valid_o, 0);
    tick();
    @(negedge clk); chk("b300_t2_valid", valid_o, 1); chk("b300_t2_addr", addr_o, 32'h300);
    chk("b300_t2_rdata", rdata_o, memf(32'h300));
    tick(); instr_gnt_i = 0; branch_i = 1; addr_i = 32'h400;
    @(negedge clk); chk("b400_iaddr", instr_addr_o, 32'h400);
    tick(); branch_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("wait_req", instr_req_o, 1); chk("wait_iaddr", instr_addr_o, 32'h400);
      tick();
    end
    branch_i = 1; addr_i = 32'h500;
    @(negedge clk); chk("b500_iaddr", instr_addr_o, 32'h500); chk("b500_req", instr_req_o, 1);
    tick(); branch_i = 0; instr_gnt_i = 1; lat = 2;
    repeat (6) tick();
    rst = 1;
    @(negedge clk); chk("mid_rst_valid", valid_o, 0); chk("mid_rst_req", instr_req_o, 0);
    tick(); rst = 0; req_i = 0;
    repeat (4) tick();
    @(negedge clk); chk("late_fill", fill_o, 0); chk("late_valid", valid_o, 0); chk("late_busy", busy_o, 0);
    tick();
    q_req = 1; q_br = 1; q_addr = 32'hFFFF_FFFC; q_gnt = 1;
    @(negedge clk); chk("w_iaddr0", q_iaddr, 32'hFFFF_FFF8);
    tick(); q_br = 0;
    @(negedge clk); chk("w_iaddr1", q_iaddr, 32'h0);
    q_rv = 1; q_rdi = 64'h1111_2222_3333_4444;
    tick(); q_rv = 1; q_rdi = 64'h5555_6666_7777_8888; q_gnt = 0;
    @(negedge clk); chk("w_valid", q_valid, 1); chk("w_addr0", q_addr_o, 32'hFFFF_FFF8);
    chk("w_rdata0", q_rdata, 64'h1111_2222_3333_4444);
    tick(); q_rv = 0; q_rdy = 1;
    @(negedge clk); chk("w_fill", q_fill, 2);
    tick();
    @(negedge clk); chk("w_addr1", q_addr_o, 32'h0); chk("w_rdata1", q_rdata, 64'h5555_6666_7777_8888);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
